// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_driver
// Brief    : Time-multiplexed 4-digit common-anode 7-segment scan driver.
//            Optional macro SEG_LEADING_ZERO_BLANK_EN adds leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_driver #(
    parameter int CLK_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digit_data,
    input  logic [3:0]  blank,
    input  logic [3:0]  dp,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp_n,
    output logic        frame
);

    localparam int             CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [15:0]      snap_data;
    logic [3:0]       snap_blank;
    logic [3:0]       snap_dp;
    logic             tick;
    logic [3:0]       load_blank;
    logic [3:0]       cur_nibble;
    logic             cur_blank;
    logic [6:0]       cur_seg;

    assign tick = (cnt == CNT_LAST);

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic [3:0] lz_mask;
    assign lz_mask[3] = (digit_data[15:12] == 4'h0);
    assign lz_mask[2] = lz_mask[3] && (digit_data[11:8] == 4'h0);
    assign lz_mask[1] = lz_mask[2] && (digit_data[7:4] == 4'h0);
    assign lz_mask[0] = 1'b0;
    assign load_blank = blank | lz_mask;
`else
    assign load_blank = blank;
`endif

    // Prescaler, digit index and once-per-frame input snapshot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= 2'd0;
            snap_data  <= 16'h0000;
            snap_blank <= 4'b1111;
            snap_dp    <= 4'b0000;
            frame      <= 1'b0;
        end else begin
            frame <= 1'b0;
            if (tick) begin
                cnt <= '0;
                idx <= idx + 2'd1;
                if (idx == 2'd3) begin
                    snap_data  <= digit_data;
                    snap_blank <= load_blank;
                    snap_dp    <= dp;
                    frame      <= 1'b1;
                end
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign cur_nibble = snap_data[{idx, 2'b00} +: 4];
    assign cur_blank  = snap_blank[idx];

    always_comb begin
        cur_seg = 7'b1111111;
        case (cur_nibble)
            4'h0: cur_seg = 7'b1000000;
            4'h1: cur_seg = 7'b1111001;
            4'h2: cur_seg = 7'b0100100;
            4'h3: cur_seg = 7'b0110000;
            4'h4: cur_seg = 7'b0011001;
            4'h5: cur_seg = 7'b0010010;
            4'h6: cur_seg = 7'b0000010;
            4'h7: cur_seg = 7'b1111000;
            4'h8: cur_seg = 7'b0000000;
            4'h9: cur_seg = 7'b0010000;
            4'hA: cur_seg = 7'b0001000;
            4'hB: cur_seg = 7'b0000011;
            4'hC: cur_seg = 7'b1000110;
            4'hD: cur_seg = 7'b0100001;
            4'hE: cur_seg = 7'b0000110;
            4'hF: cur_seg = 7'b0001110;
            default: cur_seg = 7'b1111111;
        endcase
    end

    // Registered output stage; lags idx by one cycle so pins never glitch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an   <= 4'b1111;
            seg  <= 7'b1111111;
            dp_n <= 1'b1;
        end else if (cur_blank) begin
            an   <= 4'b1111;
            seg  <= 7'b1111111;
            dp_n <= 1'b1;
        end else begin
            an   <= ~(4'b0001 << idx);
            seg  <= cur_seg;
            dp_n <= ~snap_dp[idx];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_driver
// Brief    : Self-checking bench for seg_scan_driver (reference model + directed
//            literal checks + randomized stimulus). Honors SEG_LEADING_ZERO_BLANK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_driver;

    localparam int CLK_DIV = 4;
    localparam int FRAME_LEN = 4 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digit_data = 16'h1234;
    logic [3:0]  blank = 4'b0000;
    logic [3:0]  dp = 4'b0000;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp_n;
    logic        frame;

    int tests = 0;
    int fails = 0;
    int ecnt;

    seg_scan_driver #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst(rst), .digit_data(digit_data), .blank(blank), .dp(dp),
        .an(an), .seg(seg), .dp_n(dp_n), .frame(frame)
    );

    always #5 clk = ~clk;

    // Posedges since the last reset release
    always @(posedge clk or posedge rst) begin
        if (rst) ecnt <= 0;
        else     ecnt <= ecnt + 1;
    end

    logic [6:0] seg_tbl [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [3:0] auto_blank(input logic [15:0] d);
        logic [3:0] m;
        logic lead;
        m = 4'b0000;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        lead = 1'b1;
        for (int i = 3; i >= 1; i--) begin
            lead = lead && (d[4*i +: 4] == 4'h0);
            m[i] = lead;
        end
`else
        lead = 1'b0;
        m = {4{lead}};
`endif
        return m;
    endfunction

    // Reference model: evaluated at each negedge for the posedge just passed
    initial begin
        int n;
        int d;
        logic [15:0] m_data, p_data;
        logic [3:0]  m_blank, m_dp, p_blank, p_dp;
        logic [3:0]  e_an;
        logic [6:0]  e_seg;
        logic        e_dp, e_frame;
        n = 0; m_data = 0; m_blank = 4'hF; m_dp = 0;
        p_data = 0; p_blank = 0; p_dp = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                n = 0; m_data = 16'h0; m_blank = 4'hF; m_dp = 4'h0;
                e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_frame = 1'b0;
            end else begin
                d = (n / CLK_DIV) % 4;
                if (m_blank[d]) begin
                    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
                end else begin
                    e_an = 4'hF;
                    e_an[d] = 1'b0;
                    e_seg = seg_tbl[m_data[4*d +: 4]];
                    e_dp = ~m_dp[d];
                end
                e_frame = ((n + 1) % FRAME_LEN) == 0;
                if (e_frame) begin
                    m_data = p_data;
                    m_blank = p_blank | auto_blank(p_data);
                    m_dp = p_dp;
                end
                n++;
            end
            check("model_an", int'(an), int'(e_an));
            check("model_seg", int'(seg), int'(e_seg));
            check("model_dp_n", int'(dp_n), int'(e_dp));
            check("model_frame", int'(frame), int'(e_frame));
            check("one_anode", int'($countones(~an) <= 1), 1);
            p_data = digit_data; p_blank = blank; p_dp = dp;
        end
    end

    task automatic wait_edge(input int k);
        int guard;
        guard = 0;
        while (ecnt < k && guard < 1000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (ecnt < k) check("wait_edge_timeout", ecnt, k);
    endtask

    task automatic release_rst();
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic lit(input string name, input logic [3:0] e_an, input logic [6:0] e_seg,
                       input logic e_dp);
        check({name, "_an"}, int'(an), int'(e_an));
        check({name, "_seg"}, int'(seg), int'(e_seg));
        check({name, "_dp"}, int'(dp_n), int'(e_dp));
    endtask

    initial begin
        logic [3:0] k;
        // Reset state
        #23;
        lit("reset", 4'hF, 7'h7F, 1'b1);
        check("reset_frame", int'(frame), 0);
        release_rst();

        // Basic scan of 1234
        wait_edge(5);  lit("first_frame_dark", 4'hF, 7'h7F, 1'b1);
        wait_edge(15); check("frame_pre", int'(frame), 0);
        wait_edge(16); check("frame_at16", int'(frame), 1);
        wait_edge(17); check("frame_post", int'(frame), 0);
        lit("d0_start", 4'b1110, 7'b0011001, 1'b1);
        wait_edge(20); lit("d0_end", 4'b1110, 7'b0011001, 1'b1);
        wait_edge(21); lit("d1", 4'b1101, 7'b0110000, 1'b1);
        #1 blank = 4'b1010;
        wait_edge(25); lit("d2", 4'b1011, 7'b0100100, 1'b1);
        wait_edge(29); lit("d3", 4'b0111, 7'b1111001, 1'b1);

        // Blank mask 1010
        wait_edge(33); lit("blk_d0", 4'b1110, 7'b0011001, 1'b1);
        wait_edge(37); lit("blk_d1", 4'b1111, 7'h7F, 1'b1);
        #1 begin digit_data = 16'h00A5; dp = 4'b0100; blank = 4'b0000; end
        wait_edge(41); lit("blk_d2", 4'b1011, 7'b0100100, 1'b1);
        wait_edge(45); lit("blk_d3", 4'b1111, 7'h7F, 1'b1);

        // Decimal point on digit 2, data 00A5
        wait_edge(49); lit("dp_d0", 4'b1110, 7'b0010010, 1'b1);
        wait_edge(53); lit("dp_d1", 4'b1101, 7'b0001000, 1'b1);
        #1 begin digit_data = 16'h0070; dp = 4'b0000; end
`ifdef SEG_LEADING_ZERO_BLANK_EN
        wait_edge(57); lit("dp_d2", 4'b1111, 7'h7F, 1'b1);
        wait_edge(61); lit("dp_d3", 4'b1111, 7'h7F, 1'b1);
`else
        wait_edge(57); lit("dp_d2", 4'b1011, 7'b1000000, 1'b0);
        wait_edge(61); lit("dp_d3", 4'b0111, 7'b1000000, 1'b1);
`endif

        // Leading-zero case 0070
        wait_edge(65); lit("lz_d0", 4'b1110, 7'b1000000, 1'b1);
        wait_edge(69); lit("lz_d1", 4'b1101, 7'b1111000, 1'b1);
        #1 digit_data = 16'h1111;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        wait_edge(73); lit("lz_d2", 4'b1111, 7'h7F, 1'b1);
        wait_edge(77); lit("lz_d3", 4'b1111, 7'h7F, 1'b1);
`else
        wait_edge(73); lit("lz_d2", 4'b1011, 7'b1000000, 1'b1);
        wait_edge(77); lit("lz_d3", 4'b0111, 7'b1000000, 1'b1);
`endif

        // Mid-frame change 1111 -> FFFF during the digit 1 slot
        wait_edge(86); #1 digit_data = 16'hFFFF;
        wait_edge(89); lit("mid_d2", 4'b1011, 7'b1111001, 1'b1);
        wait_edge(93); lit("mid_d3", 4'b0111, 7'b1111001, 1'b1);
        wait_edge(96); lit("mid_d3_end", 4'b0111, 7'b1111001, 1'b1);
        wait_edge(97); lit("mid_next_d0", 4'b1110, 7'b0001110, 1'b1);

        // Asynchronous reset between clock edges
        wait_edge(99);
        #2 rst = 1'b1;
        #1;
        lit("async_rst", 4'hF, 7'h7F, 1'b1);
        check("async_rst_frame", int'(frame), 0);
        repeat (2) @(posedge clk);
        #2 digit_data = 16'h1234;
        release_rst();
        wait_edge(1);  lit("rst_dark", 4'hF, 7'h7F, 1'b1);
        wait_edge(16); check("rst_frame16", int'(frame), 1);
        wait_edge(17); lit("rst_d0", 4'b1110, 7'b0011001, 1'b1);

        // Randomized traffic with one mid-run async reset
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #2;
            if ($urandom_range(0, 5) == 0) begin
                digit_data = 16'($urandom);
                k = 4'($urandom);
                blank = ($urandom_range(0, 2) == 0) ? k : 4'b0000;
                dp = 4'($urandom);
            end
            if (c == 1500) begin
                #($urandom_range(1, 6)) rst = 1'b1;
                release_rst();
            end
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
